// File: rtl/fixcplx_alu_pipe.sv
// Pipelined fixed-point complex ALU (ADD / MUL / ABSQR / MAC) with valid/ready streaming,
// round-half-up, saturation and overflow flag. Optional macro FIXCPLX_CONJ_EN adds in_conj.
module fixcplx_alu_pipe #(
    parameter int WS        = 16,
    parameter int DP        = 8,
    parameter int ACC_LEN   = 8,
    parameter int ACC_GUARD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_mode,
    input  logic [2*WS-1:0] in_a,
    input  logic [2*WS-1:0] in_b,
`ifdef FIXCPLX_CONJ_EN
    input  logic            in_conj,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*WS-1:0] out_c,
    output logic            out_ovf
);
    localparam int PW = 2*WS;
    localparam int SW = 2*WS + 1;
    localparam int AW = SW + ACC_GUARD;
    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [1:0] M_ADD = 2'd0;
    localparam logic [1:0] M_ABS = 2'd2;
    localparam logic [1:0] M_MAC = 2'd3;
    localparam logic signed [WS-1:0] W_MIN = {1'b1, {(WS-1){1'b0}}};
    localparam logic signed [WS-1:0] W_MAX = {1'b0, {(WS-1){1'b1}}};
    localparam logic signed [AW:0]   RND_HALF = (AW+1)'(1) <<< (DP-1);

    // Returns {ovf, value}; in range when all bits above the WS-bit sign agree.
    function automatic logic [WS:0] sat_ws(input logic signed [AW:0] v);
        if (v[AW:WS-1] == {(AW-WS+2){1'b0}} || v[AW:WS-1] == {(AW-WS+2){1'b1}})
            return {1'b0, v[WS-1:0]};
        else if (v[AW])
            return {1'b1, W_MIN};
        else
            return {1'b1, W_MAX};
    endfunction

    function automatic logic signed [AW:0] rnd(input logic signed [AW-1:0] v);
        logic signed [AW:0] t;
        t = (AW+1)'(v) + RND_HALF;
        return t >>> DP;
    endfunction

    logic w_en;
    logic w_in_conj;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;
`ifdef FIXCPLX_CONJ_EN
    assign w_in_conj = in_conj;
`else
    assign w_in_conj = 1'b0;
`endif

    // S1: operand register
    logic            r_s1_valid, r_s1_conj;
    logic [1:0]      r_s1_mode;
    logic [2*WS-1:0] r_s1_a, r_s1_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_conj  <= 1'b0;
            r_s1_mode  <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_conj  <= w_in_conj;
            r_s1_mode  <= in_mode;
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
        end
    end

    logic signed [WS-1:0] w_ar, w_ai, w_br, w_bi_raw, w_bi, w_mbr, w_mbi;
    logic signed [PW-1:0] w_p0, w_p1, w_p2, w_p3;
    logic signed [WS:0]   w_add_re, w_add_im;

    assign w_ar     = r_s1_a[WS-1:0];
    assign w_ai     = r_s1_a[2*WS-1:WS];
    assign w_br     = r_s1_b[WS-1:0];
    assign w_bi_raw = r_s1_b[2*WS-1:WS];
    // Conjugate negation of the most negative value clamps to the most positive one.
    assign w_bi  = !r_s1_conj ? w_bi_raw : ((w_bi_raw == W_MIN) ? W_MAX : -w_bi_raw);
    assign w_mbr = (r_s1_mode == M_ABS) ? w_ar : w_br;
    assign w_mbi = (r_s1_mode == M_ABS) ? w_ai : w_bi;
    assign w_p0  = PW'(w_ar) * PW'(w_mbr);
    assign w_p1  = PW'(w_ai) * PW'(w_mbi);
    assign w_p2  = PW'(w_ai) * PW'(w_mbr);
    assign w_p3  = PW'(w_ar) * PW'(w_mbi);
    assign w_add_re = r_s1_conj ? ((WS+1)'(w_ar) - (WS+1)'(w_br))
                                : ((WS+1)'(w_ar) + (WS+1)'(w_br));
    assign w_add_im = r_s1_conj ? ((WS+1)'(w_ai) - (WS+1)'(w_bi_raw))
                                : ((WS+1)'(w_ai) + (WS+1)'(w_bi_raw));

    // S2: full-width products
    logic                 r_s2_valid;
    logic [1:0]           r_s2_mode;
    logic signed [PW-1:0] r_s2_p0, r_s2_p1, r_s2_p2, r_s2_p3;
    logic signed [WS:0]   r_s2_add_re, r_s2_add_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_mode   <= '0;
            r_s2_p0     <= '0;
            r_s2_p1     <= '0;
            r_s2_p2     <= '0;
            r_s2_p3     <= '0;
            r_s2_add_re <= '0;
            r_s2_add_im <= '0;
        end else if (w_en) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_mode   <= r_s1_mode;
            r_s2_p0     <= w_p0;
            r_s2_p1     <= w_p1;
            r_s2_p2     <= w_p2;
            r_s2_p3     <= w_p3;
            r_s2_add_re <= w_add_re;
            r_s2_add_im <= w_add_im;
        end
    end

    // S3: sum / accumulate, round, saturate
    logic signed [SW-1:0] w_sum_re, w_sum_im;
    logic signed [AW-1:0] w_acc_re_next, w_acc_im_next;
    logic signed [AW-1:0] r_acc_re, r_acc_im;
    logic [CW-1:0]        r_cnt;
    logic                 w_last, w_emit, w_mac_beat;
    logic [WS:0]          w_res_re, w_res_im;

    assign w_sum_re = (r_s2_mode == M_ABS) ? (SW'(r_s2_p0) + SW'(r_s2_p1))
                                           : (SW'(r_s2_p0) - SW'(r_s2_p1));
    assign w_sum_im = SW'(r_s2_p2) + SW'(r_s2_p3);
    assign w_acc_re_next = r_acc_re + AW'(w_sum_re);
    assign w_acc_im_next = r_acc_im + AW'(w_sum_im);
    assign w_last     = (r_cnt == CW'(ACC_LEN - 1));
    assign w_mac_beat = r_s2_valid && (r_s2_mode == M_MAC);
    assign w_emit     = r_s2_valid && ((r_s2_mode != M_MAC) || w_last);

    always_comb begin
        w_res_re = '0;
        w_res_im = '0;
        case (r_s2_mode)
            M_ADD: begin
                w_res_re = sat_ws((AW+1)'(r_s2_add_re));
                w_res_im = sat_ws((AW+1)'(r_s2_add_im));
            end
            M_ABS: begin
                w_res_re = sat_ws(rnd(AW'(w_sum_re)));
                w_res_im = '0;
            end
            M_MAC: begin
                w_res_re = sat_ws(rnd(w_acc_re_next));
                w_res_im = sat_ws(rnd(w_acc_im_next));
            end
            default: begin
                w_res_re = sat_ws(rnd(AW'(w_sum_re)));
                w_res_im = sat_ws(rnd(AW'(w_sum_im)));
            end
        endcase
    end

    logic            r_out_valid, r_out_ovf;
    logic [2*WS-1:0] r_out_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_c     <= '0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_cnt       <= '0;
        end else if (w_en) begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_c   <= {w_res_im[WS-1:0], w_res_re[WS-1:0]};
                r_out_ovf <= w_res_re[WS] | w_res_im[WS];
            end
            if (w_mac_beat) begin
                if (w_last) begin
                    r_acc_re <= '0;
                    r_acc_im <= '0;
                    r_cnt    <= '0;
                end else begin
                    r_acc_re <= w_acc_re_next;
                    r_acc_im <= w_acc_im_next;
                    r_cnt    <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_c     = r_out_c;
    assign out_ovf   = r_out_ovf;
endmodule
